// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: widths and FSM states shared by the sequential CLA adder.
package cla_seq_pkg;
    localparam int HALF_W = 16;
    localparam int FULL_W = 32;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
endpackage

// File: rtl/fa_lookahead_16bit.sv
// fa_lookahead_16bit: two-level 16-bit carry-lookahead adder built from four 4-bit groups.
module fa_lookahead_16bit
    import cla_seq_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] sum,
    output logic              cout
);
    logic [HALF_W-1:0] g, p, c;
    logic [3:0] gg, gp;
    logic [4:0] cg;
    assign g = a & b;
    assign p = a ^ b;
    // Group carries come only from group generate/propagate, never from other carries.
    assign cg[0] = cin;
    assign cg[1] = gg[0] | (gp[0] & cin);
    assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    assign cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (genvar k = 0; k < 4; k++) begin : grp
        localparam int B = 4 * k;
        assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[k] = &p[B+3:B];
        assign c[B]   = cg[k];
        assign c[B+1] = g[B] | (p[B] & cg[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & cg[k]);
    end
    assign sum  = p ^ c;
    assign cout = cg[4];
endmodule

// File: rtl/cla_add32_arbiter.sv
// cla_add32_arbiter: two requesters share one 16-bit CLA, each 32-bit add takes a low then a high pass.
module cla_add32_arbiter
    import cla_seq_pkg::*;
#(
    parameter int ARB_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [FULL_W-1:0] req0_a,
    input  logic [FULL_W-1:0] req0_b,
    input  logic [FULL_W-1:0] req1_a,
    input  logic [FULL_W-1:0] req1_b,
    input  logic              req0_cin,
    input  logic              req1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FULL_W-1:0] rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_id,
    output logic              busy
);
    state_t state;
    logic last, gnt1, accept, hi, cin_r, id_r, c_lo, add_cin, add_cout;
    logic [FULL_W-1:0] a_r, b_r;
    logic [HALF_W-1:0] sum_lo, add_a, add_b, add_sum;
    // last holds the most recent grant; req1 wins a tie only in round-robin after req0 went last.
    assign gnt1       = req1_valid && (!req0_valid || ((ARB_MODE != 0) && !last));
    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !gnt1;
    assign req1_ready = accept && gnt1;
    assign hi         = state == HI;
    assign add_a      = hi ? a_r[FULL_W-1:HALF_W] : a_r[HALF_W-1:0];
    assign add_b      = hi ? b_r[FULL_W-1:HALF_W] : b_r[HALF_W-1:0];
    assign add_cin    = hi ? c_lo : cin_r;
    assign rsp_valid  = state == DONE;
    assign busy       = state != IDLE;
    fa_lookahead_16bit u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= LO;
                    last  <= gnt1;
                end
                LO: state <= HI;
                HI: begin
                    state    <= DONE;
                    rsp_sum  <= {add_sum, sum_lo};
                    rsp_cout <= add_cout;
                    rsp_id   <= id_r;
                end
                DONE: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= gnt1 ? req1_a : req0_a;
            b_r   <= gnt1 ? req1_b : req0_b;
            cin_r <= gnt1 ? req1_cin : req0_cin;
            id_r  <= gnt1;
        end
        if (state == LO) begin
            sum_lo <= add_sum;
            c_lo   <= add_cout;
        end
    end
endmodule
